// File: rtl/demux1to4_tdm.sv
// 1-to-4 time-division demultiplexer.
// Collects four serial bits per frame, aligned on a slot-0 Sync marker, and
// presents each complete frame in parallel on Out. A small HUNT/LOCKED FSM
// tracks alignment and drops lock after MISS_MAX consecutive frame starts
// arrive without Sync.
//
// Handshake: En qualifies In and Sync. A cycle with En=0 carries no bit and
// changes no state. FrameValid and SyncErr are single-cycle pulses with no
// back-pressure; a consumer must take Out on the cycle FrameValid is high.
module demux1to4_tdm #(
  parameter int MISS_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       In,
  input  logic       En,
  input  logic       Sync,
  output logic [3:0] Out,
  output logic       FrameValid,
  output logic       Locked,
  output logic       SyncErr,
  output logic       dbg_state,
  output logic [1:0] dbg_slot
);

  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  logic [1:0]    slot;
  logic [3:0]    hold;
  logic [MW-1:0] miss;

  // Debug view of the FSM and slot position.
  assign dbg_state = state;
  assign dbg_slot  = slot;

  // Frame alignment FSM, bit capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      hold       <= 4'b0000;
      miss       <= '0;
      Out        <= 4'b0000;
      FrameValid <= 1'b0;
      Locked     <= 1'b0;
      SyncErr    <= 1'b0;
    end else begin
      // Pulses default low; they fire only on enabled cycles below.
      FrameValid <= 1'b0;
      SyncErr    <= 1'b0;
      if (En) begin
        case (state)
          HUNT: begin
            // Bits before the first Sync carry no alignment and are dropped.
            if (Sync) begin
              hold[0] <= In;
              slot    <= 2'd1;
              miss    <= '0;
              state   <= LOCKED;
              Locked  <= 1'b1;
            end
          end
          LOCKED: begin
            if (Sync && (slot != 2'd0)) begin
              // Sync off slot 0: the current frame is corrupt, restart it
              // with this bit as slot 0 and never report it.
              SyncErr <= 1'b1;
              hold    <= {3'b000, In};
              slot    <= 2'd1;
              miss    <= '0;
            end else begin
              hold[slot] <= In;
              slot       <= slot + 2'd1;
              if (slot == 2'd3) begin
                Out        <= {In, hold[2:0]};
                FrameValid <= 1'b1;
              end
              if (slot == 2'd0) begin
                if (Sync) begin
                  miss <= '0;
                end else if (miss + MW'(1) == MISS_LIM) begin
                  // Too many unmarked frame starts: give up alignment,
                  // discard the partial frame, keep the last Out.
                  state  <= HUNT;
                  Locked <= 1'b0;
                  slot   <= 2'd0;
                  miss   <= '0;
                  hold   <= 4'b0000;
                end else begin
                  miss <= miss + MW'(1);
                end
              end
            end
          end
          default: begin
            state  <= HUNT;
            Locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
